// File: rtl/sitcp_timer_pkg.sv
// Shared types and constants for the SiTCP timer generator and its user channels.
package sitcp_timer_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam logic [3:0] UNIT_1US = 4'd0;
    localparam logic [3:0] UNIT_1MS = 4'd3;
    localparam logic [3:0] UNIT_1S  = 4'd6;

    // Channel period/count fields are held at this width; PW must not exceed it.
    localparam int PW_MAX = 32;

    typedef struct packed {
        logic              active;
        logic              mode;
        logic [3:0]        unit;
        logic [PW_MAX-1:0] period;
        logic [PW_MAX-1:0] cnt;
    } ch_state_t;

endpackage

// File: rtl/sitcp_timer_gen_if.sv
// Timer strobes, uptime and channel configuration bus between the timer and its host.
interface sitcp_timer_gen_if #(
    parameter int NUM_DECADES = 8,
    parameter int N_CH        = 4,
    parameter int PW          = 16
);
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [NUM_DECADES:0] tim_tick;
    logic                 tim_1m;
    logic [31:0]          uptime_s;
    logic                 cfg_we;
    logic [CHW-1:0]       cfg_ch;
    logic [PW-1:0]        cfg_period;
    logic [3:0]           cfg_unit;
    logic                 cfg_mode;
    logic                 cfg_en;
    logic [N_CH-1:0]      ch_active;
    logic [N_CH-1:0]      ch_fire;

    modport master (
        output cfg_we, cfg_ch, cfg_period, cfg_unit, cfg_mode, cfg_en,
        input  tim_tick, tim_1m, uptime_s, ch_active, ch_fire
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_period, cfg_unit, cfg_mode, cfg_en,
        output tim_tick, tim_1m, uptime_s, ch_active, ch_fire
    );
endinterface

// File: rtl/sitcp_timer_ch.sv
// One programmable user timer channel: down-counts ticks of a selected decade and
// strobes on expiry, reloading (periodic) or disarming (one-shot).
module sitcp_timer_ch
    import sitcp_timer_pkg::*;
#(
    parameter int NUM_TICKS = 9,
    parameter int PW        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_TICKS-1:0] tick_i,
    input  logic                 wr_i,
    input  logic [PW-1:0]        period_i,
    input  logic [3:0]           unit_i,
    input  logic                 mode_i,
    input  logic                 en_i,
    output logic                 active_o,
    output logic                 fire_o
);

    ch_state_t         st_q, st_d;
    logic              unit_tick;
    logic              expire;
    logic [PW_MAX-1:0] period_ext;

    assign period_ext = PW_MAX'(period_i);

    always_comb begin
        unit_tick = 1'b0;
        for (int i = 0; i < NUM_TICKS; i++) begin
            if (st_q.unit == 4'(i)) unit_tick = tick_i[i];
        end
    end

    assign expire   = st_q.active & unit_tick & (st_q.cnt == PW_MAX'(1));
    // A write in the expiring cycle pre-empts the strobe.
    assign fire_o   = expire & ~wr_i & ~rst_i;
    assign active_o = st_q.active;

    always_comb begin
        st_d = st_q;
        if (wr_i) begin
            st_d.unit   = unit_i;
            st_d.mode   = mode_i;
            st_d.period = period_ext;
            if (en_i && (period_i != '0)) begin
                st_d.cnt    = period_ext;
                st_d.active = 1'b1;
            end else begin
                st_d.active = 1'b0;
            end
        end else if (st_q.active && unit_tick) begin
            if (expire) begin
                if (st_q.mode == MODE_ONESHOT) st_d.active = 1'b0;
                else                           st_d.cnt    = st_q.period;
            end else begin
                st_d.cnt = st_q.cnt - PW_MAX'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) st_q <= '0;
        else       st_q <= st_d;
    end

endmodule

// File: rtl/sitcp_timer_gen.sv
// Decade timer for SiTCP (1 us .. 10^NUM_DECADES us strobes, 1 min strobe, uptime)
// plus N_CH programmable user channels.
module sitcp_timer_gen
    import sitcp_timer_pkg::*;
#(
    parameter int CLK_FREQ    = 125,
    parameter int NUM_DECADES = 8,
    parameter int N_CH        = 4,
    parameter int PW          = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    sitcp_timer_gen_if.slave bus
);

    localparam int PSW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int NT  = NUM_DECADES + 1;
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [PSW-1:0]               presc_q, presc_d;
    logic                         tick0_q;
    logic [NUM_DECADES:1][3:0]    dec_q, dec_d;
    logic [5:0]                   min_q, min_d;
    logic [31:0]                  uptime_q, uptime_d;
    logic [NT-1:0]                tick;
    logic                         presc_last;
    logic                         run;
    logic                         valid_unit;
    logic [N_CH-1:0]              wr;

    assign presc_last = (presc_q == PSW'(CLK_FREQ - 1));

    // Every decade strobe is the 1 us register ANDed with the all-nines of the
    // lower decades, so coincident strobes rise in the same cycle.
    always_comb begin
        presc_d = presc_last ? '0 : presc_q + 1'b1;
        run     = tick0_q & ~rst_i;
        tick[0] = run;
        for (int k = 1; k <= NUM_DECADES; k++) begin
            run     = run & (dec_q[k] == 4'd9);
            tick[k] = run;
        end
        dec_d = dec_q;
        for (int k = 1; k <= NUM_DECADES; k++) begin
            if (tick[k-1]) dec_d[k] = (dec_q[k] == 4'd9) ? 4'd0 : dec_q[k] + 4'd1;
        end
        min_d    = min_q;
        uptime_d = uptime_q;
        if (tick[UNIT_1S]) begin
            min_d    = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            uptime_d = uptime_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q  <= '0;
            tick0_q  <= 1'b0;
            dec_q    <= '0;
            min_q    <= '0;
            uptime_q <= '0;
        end else begin
            presc_q  <= presc_d;
            tick0_q  <= presc_last;
            dec_q    <= dec_d;
            min_q    <= min_d;
            uptime_q <= uptime_d;
        end
    end

    assign bus.tim_tick = tick;
    assign bus.tim_1m   = tick[UNIT_1S] & (min_q == 6'd59);
    assign bus.uptime_s = uptime_q;

    assign valid_unit = (bus.cfg_unit <= 4'(NUM_DECADES));

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign wr[c] = bus.cfg_we & valid_unit & (bus.cfg_ch == CHW'(c));

        sitcp_timer_ch #(
            .NUM_TICKS (NT),
            .PW        (PW)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .tick_i   (tick),
            .wr_i     (wr[c]),
            .period_i (bus.cfg_period),
            .unit_i   (bus.cfg_unit),
            .mode_i   (bus.cfg_mode),
            .en_i     (bus.cfg_en),
            .active_o (bus.ch_active[c]),
            .fire_o   (bus.ch_fire[c])
        );
    end

endmodule
